mul_seq: RTL

- Parametrised, sequential radix-2 shift-add multiplier. Second-generation block after the team's fixed 4-bit array multiplier.
- Generalised to WIDTH-bit operands, with per-transaction signed/unsigned mode.
- Valid/ready handshakes on input and output, so it drops into streaming datapaths with backpressure.
- One multiply in flight; fixed latency of WIDTH cycles.

---
 rtl/mul_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mul_seq.sv
// mul_seq: sequential radix-2 shift-add multiplier with valid/ready handshakes.
// Signed operands are reduced to magnitudes at accept time, multiplied unsigned
// over exactly WIDTH iterations, and the sign is applied when the product loads.
module mul_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_next;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [CNT_W-1:0]   cnt;
    logic               neg;
    logic               last_iter;

    // Operand magnitudes and the next accumulator value for the current iteration.
    always_comb begin
        a_mag     = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag     = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        acc_sum   = acc + (mplier[0] ? mcand : '0);
        last_iter = (cnt == LAST_ITER);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake/status outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, shift-add iterations and signed product load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        acc    <= '0;
                        cnt    <= '0;
                        neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    end
                end
                CALC: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    // The final partial sum is taken combinationally so the
                    // product lands on the WIDTH-th edge without an extra cycle.
                    if (last_iter) begin
                        product <= neg ? (~acc_sum + (2*WIDTH)'(1)) : acc_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
